// File: rtl/ddr_button_events.sv
// ddr_button_events: debounced direction buttons -> arrow-code event FIFO with valid/ready.
// Optional auto-repeat of held buttons when DDR_BUTTON_AUTOREPEAT_EN is defined.
module ddr_button_events #(
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
    parameter int          FIFO_DEPTH      = 4,
    parameter int          FIFO_AW         = 2
`ifdef DDR_BUTTON_AUTOREPEAT_EN
    ,
    parameter logic [31:0] REPEAT_DELAY    = 32'd50000000,
    parameter logic [31:0] REPEAT_PERIOD   = 32'd10000000
`endif
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic               btnU,
    input  logic               btnD,
    input  logic               btnL,
    input  logic               btnR,
    input  logic               clear_ovf,
    output logic               evt_valid,
    output logic [1:0]         evt_dir,
    input  logic               evt_ready,
    output logic [3:0]         btn_level,
    output logic [FIFO_AW:0]   fifo_count,
    output logic               overflow
);
    logic [3:0]        raw, syncA, syncB, stable, stableNext, rise;
    logic [3:0][15:0]  dbCnt, dbCntNext;
    logic [3:0]        pending, pendingNext, grant, repeatSet;
    logic [1:0]        grantDir, pushDir;
    logic              pushVld, pop, accept, drop;
    logic [1:0]        fifoMem [FIFO_DEPTH];
    logic [FIFO_AW-1:0] rdPtr, wrPtr;
    logic [FIFO_AW:0]  count, countNext;

    assign raw = {btnR, btnL, btnD, btnU};

    always_comb begin
        stableNext = stable;
        dbCntNext  = '0;
        for (int i = 0; i < 4; i++) begin
            if (syncB[i] != stable[i]) begin
                if (dbCnt[i] == DEBOUNCE_CYCLES - 16'd1)
                    stableNext[i] = ~stable[i];
                else
                    dbCntNext[i] = dbCnt[i] + 16'd1;
            end
        end
    end

    assign rise        = stableNext & ~stable;
    assign grant       = pending & (~pending + 4'd1);
    assign grantDir    = pending[0] ? 2'd0 : pending[1] ? 2'd1 : pending[2] ? 2'd2 : 2'd3;
    assign pendingNext = enable ? ((pending & ~grant) | rise | repeatSet) : 4'd0;

    // Arbiter output is registered; the FIFO write happens one edge after selection.
    assign evt_valid = count != '0;
    assign evt_dir   = evt_valid ? fifoMem[rdPtr] : 2'd0;
    assign pop       = evt_valid && evt_ready;
    assign accept    = pushVld && (!count[FIFO_AW] || pop);
    assign drop      = pushVld && count[FIFO_AW] && !pop;
    assign countNext = (accept && !pop) ? count + (FIFO_AW+1)'(1) :
                       (pop && !accept) ? count - (FIFO_AW+1)'(1) : count;

    assign btn_level  = stable;
    assign fifo_count = count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            syncA    <= '0;
            syncB    <= '0;
            stable   <= '0;
            dbCnt    <= '0;
            pending  <= '0;
            pushVld  <= 1'b0;
            pushDir  <= '0;
            rdPtr    <= '0;
            wrPtr    <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            syncA    <= raw;
            syncB    <= syncA;
            stable   <= stableNext;
            dbCnt    <= dbCntNext;
            pending  <= pendingNext;
            pushVld  <= enable && (pending != 4'd0);
            pushDir  <= grantDir;
            if (accept)
                wrPtr <= wrPtr + FIFO_AW'(1);
            if (pop)
                rdPtr <= rdPtr + FIFO_AW'(1);
            count    <= countNext;
            overflow <= drop || (overflow && !clear_ovf);
        end
    end

    always_ff @(posedge clk) begin
        if (accept)
            fifoMem[wrPtr] <= pushDir;
    end

`ifdef DDR_BUTTON_AUTOREPEAT_EN
    logic [3:0][31:0] rptTimer;
    logic [3:0]       rptArmed, rptFirst;

    always_comb begin
        repeatSet = '0;
        for (int i = 0; i < 4; i++)
            repeatSet[i] = rptArmed[i] && stable[i] && enable &&
                           rptTimer[i] == (rptFirst[i] ? REPEAT_DELAY : REPEAT_PERIOD) - 32'd1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rptTimer <= '0;
            rptArmed <= '0;
            rptFirst <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (rise[i] && enable) begin
                    rptArmed[i] <= 1'b1;
                    rptFirst[i] <= 1'b1;
                    rptTimer[i] <= '0;
                end else if (!stableNext[i] || !enable) begin
                    rptArmed[i] <= 1'b0;
                    rptTimer[i] <= '0;
                end else if (repeatSet[i]) begin
                    rptFirst[i] <= 1'b0;
                    rptTimer[i] <= '0;
                end else if (rptArmed[i]) begin
                    rptTimer[i] <= rptTimer[i] + 32'd1;
                end
            end
        end
    end
`else
    assign repeatSet = 4'd0;
`endif
endmodule

// File: tb/tb_ddr_button_events.sv
// tb_ddr_button_events: randomized + directed scoreboard bench for ddr_button_events.
module tb_ddr_button_events;
    localparam int D = 4;

    logic       clk = 1'b0, reset = 1'b0, enable = 1'b0, clear_ovf = 1'b0, evt_ready = 1'b0;
    logic       btnU = 1'b0, btnD = 1'b0, btnL = 1'b0, btnR = 1'b0;
    logic       evt_valid, overflow;
    logic [1:0] evt_dir;
    logic [3:0] btn_level;
    logic [2:0] fifo_count;

    int total = 0;
    int bad = 0;
    int expQ[$];

    ddr_button_events #(.DEBOUNCE_CYCLES(16'd4), .FIFO_DEPTH(4), .FIFO_AW(2)) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .btnU(btnU), .btnD(btnD), .btnL(btnL), .btnR(btnR),
        .clear_ovf(clear_ovf), .evt_valid(evt_valid), .evt_dir(evt_dir),
        .evt_ready(evt_ready), .btn_level(btn_level), .fifo_count(fifo_count),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic check(string name, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", name, act, exp);
        end
    endtask

    task automatic tick(int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic setBtn(logic [3:0] m);
        {btnR, btnL, btnD, btnU} = m;
    endtask

    task automatic press(logic [3:0] m);
        setBtn(m);
        tick(D + 3);
        setBtn(4'd0);
        tick(D + 3);
    endtask

    task automatic drain();
        int n = 0;
        evt_ready = 1'b1;
        while (evt_valid && n < 60) begin
            tick();
            n++;
        end
        check("drain_empty", int'(evt_valid), 0);
        evt_ready = 1'b0;
    endtask

    // Reference: every button held for >= D samples while enabled yields one event;
    // buttons pressed on the same edge enter in U,D,L,R order; shorter glitches yield none.
    task automatic phase();
        logic [3:0] m, g;
        int hold, glen;
        logic en;
        m    = 4'($urandom_range(1, 15));
        g    = 4'($urandom) & ~m;
        hold = D + $urandom_range(0, 5);
        glen = $urandom_range(1, D - 1);
        en   = ($urandom % 5) != 0;
        enable = en;
        if (en)
            for (int i = 0; i < 4; i++)
                if (m[i]) expQ.push_back(i);
        setBtn(m | g);
        for (int t = 0; t < hold; t++) begin
            if (t == glen) setBtn(m);
            evt_ready = ($urandom % 4) != 0;
            tick();
        end
        setBtn(4'd0);
        for (int t = 0; t < D + 4; t++) begin
            evt_ready = ($urandom % 4) != 0;
            tick();
        end
        drain();
        check("rnd_level", int'(btn_level), 0);
    endtask

    always @(negedge clk) begin
        if (reset && evt_valid && evt_ready) begin
            if (expQ.size() == 0)
                check("sb_unexpected", int'(evt_dir), -1);
            else
                check("sb_dir", int'(evt_dir), expQ.pop_front());
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        int n;
        int seen;
        tick(2);
        check("rst_valid", int'(evt_valid), 0);
        check("rst_dir", int'(evt_dir), 0);
        check("rst_level", int'(btn_level), 0);
        check("rst_count", int'(fifo_count), 0);
        check("rst_ovf", int'(overflow), 0);
        reset = 1'b1;
        enable = 1'b1;
        tick(2);

        // latency of a single held press
        setBtn(4'b0100);
        tick(D + 3);
        check("lat_early", int'(evt_valid), 0);
        tick();
        check("lat_valid", int'(evt_valid), 1);
        check("lat_dir", int'(evt_dir), 2);
        expQ.push_back(2);
        drain();
        tick(10);
        check("held_no_repeat", int'(fifo_count), 0);
        check("held_level", int'(btn_level), 4);
        setBtn(4'd0);
        tick(D + 4);

        // glitch shorter than the debounce window
        setBtn(4'b0001);
        tick(3);
        setBtn(4'd0);
        seen = 0;
        repeat (12) begin
            tick();
            if (btn_level != 4'd0 || evt_valid) seen++;
        end
        check("glitch", seen, 0);

        // simultaneous U and R
        setBtn(4'b1001);
        n = 0;
        while (!evt_valid && n < 20) begin
            tick();
            n++;
        end
        check("simul_valid", int'(evt_valid), 1);
        check("simul_cnt1", int'(fifo_count), 1);
        check("simul_head", int'(evt_dir), 0);
        tick();
        check("simul_cnt2", int'(fifo_count), 2);
        setBtn(4'd0);
        tick(D + 4);
        expQ.push_back(0);
        expQ.push_back(3);
        drain();

        // overflow on the fifth press
        press(4'b0001);
        press(4'b0010);
        press(4'b0100);
        press(4'b1000);
        press(4'b0001);
        check("ovf_cnt", int'(fifo_count), 4);
        check("ovf_set", int'(overflow), 1);
        clear_ovf = 1'b1;
        tick();
        clear_ovf = 1'b0;
        check("ovf_clear", int'(overflow), 0);

        // push and pop on the same edge while full
        expQ.push_back(0);
        expQ.push_back(1);
        expQ.push_back(2);
        expQ.push_back(3);
        expQ.push_back(2);
        setBtn(4'b0100);
        tick(D + 3);
        evt_ready = 1'b1;
        tick();
        evt_ready = 1'b0;
        check("full_pp_cnt", int'(fifo_count), 4);
        check("full_pp_ovf", int'(overflow), 0);
        setBtn(4'd0);
        tick(D + 4);
        drain();
        evt_ready = 1'b1;
        tick(3);
        evt_ready = 1'b0;
        check("pop_empty", int'(fifo_count), 0);

        // enable low discards the press but level still follows
        enable = 1'b0;
        setBtn(4'b0010);
        tick(D + 4);
        check("dis_level", int'(btn_level[1]), 1);
        check("dis_cnt", int'(fifo_count), 0);
        tick(4);
        check("dis_cnt_late", int'(fifo_count), 0);
        setBtn(4'd0);
        tick(D + 4);
        enable = 1'b1;

        // asynchronous reset with three queued events
        press(4'b0001);
        press(4'b0010);
        press(4'b0100);
        check("pre_rst_cnt", int'(fifo_count), 3);
        reset = 1'b0;
        #1;
        check("arst_valid", int'(evt_valid), 0);
        check("arst_cnt", int'(fifo_count), 0);
        check("arst_ovf", int'(overflow), 0);
        expQ.delete();
        tick(2);
        reset = 1'b1;
        tick(2);

        repeat (40) phase();
        enable = 1'b1;
        check("end_ovf", int'(overflow), 0);
        check("sb_empty", expQ.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ddr_button_events.md
Name: ddr_button_events

Overview:
- Input-side counterpart to the game's seven-segment display driver.
- Converts the four raw direction buttons (btnU/btnD/btnL/btnR) into clean, single-cycle press events, each encoded as an arrow code.
- Events are queued in a small FIFO with a valid/ready handshake, so the collision logic gets exactly one event per physical press, even when several buttons are pressed together.
- Sits between the board pins and the collision/score logic; clocked on the 100 MHz system clk.

Parameters:
- DEBOUNCE_CYCLES, 16'd50000, number of consecutive cycles a synchronized input must differ from its stable value before the stable value flips (range 2..65535).
- FIFO_DEPTH, 4, event FIFO entries; power of two, 2..16.
- FIFO_AW, 2, log2(FIFO_DEPTH).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- enable  input  1  high = game running; low discards new press events (pause/menu).
- btnU  input  1  raw up button, asynchronous.
- btnD  input  1  raw down button, asynchronous.
- btnL  input  1  raw left button, asynchronous.
- btnR  input  1  raw right button, asynchronous.
- clear_ovf  input  1  single-cycle pulse; clears overflow.
- evt_valid  output  1  FIFO head holds an event.
- evt_dir  output  2  head event code: 0=up, 1=down, 2=left, 3=right; 0 when empty.
- evt_ready  input  1  consumer accepts the head when evt_valid && evt_ready.
- btn_level  output  4  debounced stable levels, bit order {R,L,D,U}.
- fifo_count  output  FIFO_AW+1  current occupancy.
- overflow  output  1  sticky; at least one event was dropped.

Behaviour:
- Reset (reset=0, immediate):
  - sync flops, stable levels, debounce counters, pending bits, FIFO pointers and overflow all go to 0.
  - Outputs: evt_valid=0, evt_dir=0, btn_level=0, fifo_count=0, overflow=0.
  - Reset release is sampled on the first clk edge with reset=1.
  - Reset mid-debounce or mid-queue discards all state; a button still held after reset is treated as a fresh press once debounced.
- Synchronizer: each button passes through a 2-flop synchronizer.
- Debounce (per button, 16-bit counter):
  - If sync != stable, the counter increments.
  - When the counter reaches DEBOUNCE_CYCLES-1 while still mismatched, stable flips and the counter clears.
  - Any cycle with sync == stable clears the counter. A glitch shorter than DEBOUNCE_CYCLES never changes stable.
- Press detect: a stable 0->1 transition sets that button's pending bit on the same edge, only if enable=1. A 1->0 transition (release) produces no event.
- Arbiter:
  - Each cycle, the lowest-index pending bit (U > D > L > R) is pushed into the FIFO and its pending bit cleared.
  - One push per cycle; simultaneous presses enter in priority order on consecutive cycles.
  - A pending bit set in the same cycle that another is cleared is retained.
- Enable deassert: all pending bits clear on the next edge. FIFO contents are kept.
- FIFO: show-ahead.
  - evt_valid = (count != 0); evt_dir = head entry.
  - Pop occurs when evt_valid && evt_ready.
  - Pointers wrap modulo FIFO_DEPTH.
  - Push and pop in the same cycle leave count unchanged, including when full (push accepted) and when count=1.
  - A pop while empty is ignored.
- Overflow:
  - If the arbiter pushes while full and no pop occurs that cycle, the event is dropped, its pending bit is still cleared, and overflow is set.
  - clear_ovf clears overflow. If clear_ovf coincides with a new drop, overflow stays 1.
- Latency: first edge sampling raw=1 to evt_valid=1 is exactly DEBOUNCE_CYCLES+4 cycles with an empty FIFO and no competing pending bits.

Optional Feature:
- Macro: DDR_BUTTON_AUTOREPEAT_EN.
- Defined:
  - Adds parameters REPEAT_DELAY (default 32'd50000000) and REPEAT_PERIOD (default 32'd10000000).
  - A button stably held with enable=1 re-sets its pending bit REPEAT_DELAY cycles after its press event, then every REPEAT_PERIOD cycles until release or enable=0.
  - Uses one 32-bit timer per button.
- Undefined: no repeat logic; exactly one event per press.

Test Plan:
- DEBOUNCE_CYCLES=4, FIFO_DEPTH=4, enable=1; hold btnL high from cycle 0 -> evt_valid=1, evt_dir=2 at cycle 8; evt_ready=1 pops it; no further event while held.
- btnU pulsed high for 3 cycles (shorter than the 4-cycle debounce window) -> btn_level stays 0, evt_valid never asserts.
- btnR and btnU rise on the same edge, evt_ready=0 -> FIFO holds up(0) then right(3); fifo_count reaches 2 one cycle apart; pops return 0 then 3.
- Five distinct debounced presses with evt_ready=0 -> fifo_count=4, fifth event dropped, overflow=1; clear_ovf pulse -> overflow=0; four pops return the first four codes in order.
- enable=0 during a debounced btnD press -> no event, btn_level[1]=1; assert reset=0 mid-FIFO with count=3 -> evt_valid=0, fifo_count=0, overflow=0 immediately, without waiting for a clock edge.
